// File: rtl/toggle_hs_receiver.sv
// Receive end of a two-phase toggle handshake: synchronises req_tog, captures req_data
// into a valid/ready output register and returns ack_tog once the word is consumed.
//
// state | meaning
// IDLE  | no word held, waiting for a req toggle
// HOLD  | word held on out_data, waiting for out_ready
module toggle_hs_receiver #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tog,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tog,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              protocol_err,
    output logic [CNT_W-1:0]  xfer_count
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     req_prev_q, req_prev_d;
    logic                     ack_q, ack_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     err_q, err_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     req_s;
    logic                     toggle;

    assign req_s  = sync_q[SYNC_STAGES-1];
    assign toggle = req_s ^ req_prev_q;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], req_tog};
        state_d     = state_q;
        req_prev_d  = req_prev_q;
        ack_d       = ack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (toggle) begin
                    out_data_d  = req_data;
                    out_valid_d = 1'b1;
                    req_prev_d  = req_s;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = ~ack_q;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
                // A toggle while a word is still held is flagged and consumed, never captured.
                if (toggle) begin
                    err_d      = 1'b1;
                    req_prev_d = req_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            req_prev_q  <= 1'b0;
            ack_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            req_prev_q  <= req_prev_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ack_tog      = ack_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign protocol_err = err_q;
    assign xfer_count   = cnt_q;

endmodule

// File: doc/toggle_hs_receiver.md
Name: toggle_hs_receiver

Overview:
Responder (receive) end of a two-phase toggle handshake used to move a data word from an unrelated clock domain into the clk domain. The sender flips req_tog once per word while holding req_data stable. This block synchronises req_tog, detects the toggle and captures req_data. It presents the word on a valid/ready interface and flips ack_tog back to the sender once the word is consumed.

Parameters:
DATA_W, 8, width of req_data / out_data
SYNC_STAGES, 2, flops in the req_tog synchroniser chain (legal range 2..4)
CNT_W, 16, width of xfer_count

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_tog  in  1  request toggle from sender (asynchronous to clk)
req_data  in  DATA_W  sender data, stable from before req_tog flips until ack_tog is seen
ack_tog  out  1  acknowledge toggle back to sender
out_valid  out  1  out_data holds an unconsumed word
out_data  out  DATA_W  captured word
out_ready  in  1  downstream accepts word when high with out_valid
protocol_err  out  1  sticky: req toggled again before ack
xfer_count  out  CNT_W  completed transfers, wraps

Behaviour:
- Reset (reset high at a rising edge) clears all of the following to 0: sync chain, req_prev, ack_tog, out_valid, out_data, protocol_err, xfer_count, state (IDLE). Reset mid-transfer discards the held word with no ack. The sender must be reset together with this block, and req_tog must be 0 at reset release; a 1 is treated as a toggle.
- Synchroniser: req_tog passes through SYNC_STAGES flops to give req_s. req_prev holds the last accepted req_s. A toggle event is present when req_s differs from req_prev.
- req_data is not synchronised. It is sampled directly, relying on the sender's stability guarantee.
- States:
  - IDLE: out_valid=0. On toggle event: out_data<=req_data, out_valid<=1, req_prev<=req_s, go to HOLD.
  - HOLD: out_valid=1, and out_data is held constant. When out_valid & out_ready at a rising edge: out_valid<=0, ack_tog<=~ack_tog, xfer_count<=xfer_count+1 (modulo 2^CNT_W), go to IDLE.
- Latency: if req_tog changes between edges E-1 and E0, out_valid is high after edge E(SYNC_STAGES). For SYNC_STAGES=2 that is exactly 2 clocks after the first sampling edge. ack_tog flips at the same edge where out_valid falls.
- The earliest next capture is 1 cycle after the ack. The throughput limit is set by the sender's ack synchronisation.
- Toggle event in HOLD is a protocol violation:
  - protocol_err<=1 (sticky until reset) and req_prev<=req_s.
  - out_data is NOT overwritten and no extra transfer or ack is generated.
  - This applies even if a handshake completes in the same cycle: the handshake completes normally, and the new toggle is counted as an error, not captured.
- out_ready is ignored in IDLE.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset: hold reset 3 cycles with req_tog=0, out_ready=1 -> ack_tog, out_valid, out_data, protocol_err, xfer_count all 0; no activity for 10 cycles after release.
2. Single transfer (SYNC_STAGES=2): req_data=0xA5, req_tog 0->1 before edge E0 -> out_valid=1 and out_data=0xA5 after E2; out_ready=1 -> after the next edge out_valid=0, ack_tog=1, xfer_count=1.
3. Backpressure: as test 2 with out_ready=0 for 10 cycles -> out_valid stays 1, out_data stays 0xA5, ack_tog stays 0; raise out_ready -> ack_tog flips one edge later.
4. Back-to-back: sender model sends 0x01,0x02,0x03,0x04, toggling only after seeing each ack -> out_data observed in order at each handshake, xfer_count=4, ack_tog=0, protocol_err=0.
5. Protocol error: send 0x11, then toggle req_tog again (req_data=0x22) while out_ready=0 -> protocol_err=1, out_data remains 0x11; after out_ready=1 exactly one handshake, xfer_count=1, no capture of 0x22; protocol_err stays 1 until reset.
6. Reset mid-HOLD and count wrap:
   - Assert reset while out_valid=1 -> next cycle out_valid=0, ack_tog=0.
   - Separately force/preload 0xFFFF transfers -> xfer_count wraps to 0x0000 on the next handshake.
